cache_tag_controller: RTL

Tag/state controller for the N-way set-associative cache. Consumes the tag and index fields produced by the address splitter and compares them against per-set tag, valid and dirty state. It reports hit/miss and the selected way to the data-array side, runs dirty-victim writeback and line refill handshakes with the memory port, and maintains true-LRU replacement.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/lru_tracker.sv | 61 ++++++
 rtl/cache_tag_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache tag/state controller.
// Holds the controller state encoding, way-index width derivation and block-address packing.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_RF_REQ,
        ST_RF_WAIT,
        ST_RESPOND
    } state_e;

    function automatic int way_bits(input int n_ways);
        return (n_ways > 1) ? $clog2(n_ways) : 1;
    endfunction

    // Callers truncate the result to their own address width.
    function automatic logic [63:0] block_addr(input logic [63:0] tag,
                                               input logic [63:0] index,
                                               input int          index_bits,
                                               input int          offset_bits);
        return ((tag << index_bits) | index) << offset_bits;
    endfunction

endpackage

// File: rtl/lru_tracker.sv
// True-LRU age storage, one WAY_BITS age per way per set.
// Ages in a set stay a permutation of 0..N_WAYS-1. The victim is the way whose age is N_WAYS-1.
module lru_tracker
    import cache_pkg::*;
#(
    parameter  int N_WAYS     = 2,
    parameter  int NUM_SETS   = 32,
    parameter  int INDEX_BITS = 5,
    localparam int WAY_BITS   = way_bits(N_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [WAY_BITS-1:0]   upd_way,
    input  logic [INDEX_BITS-1:0] vic_index,
    output logic [WAY_BITS-1:0]   vic_way
);

    logic [WAY_BITS-1:0] age_q [NUM_SETS][N_WAYS];
    logic [WAY_BITS-1:0] age_d [NUM_SETS][N_WAYS];
    logic [WAY_BITS-1:0] old_age;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        age_d   = age_q;
        old_age = age_q[upd_index][upd_way];
        if (upd_en) begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (WAY_BITS'(w) == upd_way) begin
                    age_d[upd_index][w] = '0;
                end else if (age_q[upd_index][w] < old_age) begin
                    age_d[upd_index][w] = age_q[upd_index][w] + WAY_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < N_WAYS; w++) begin
                    age_q[s][w] <= WAY_BITS'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        vic_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (age_q[vic_index][w] == WAY_BITS'(N_WAYS - 1)) begin
                vic_way = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/cache_tag_controller.sv
// Tag/valid/dirty controller for an N-way set-associative cache.
// Services one CPU lookup at a time, with dirty-victim writeback and refill over the memory port.
module cache_tag_controller
    import cache_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int N_WAYS      = 2,
    parameter  int NUM_SETS    = 32,
    parameter  int OFFSET_BITS = 7,
    parameter  int INDEX_BITS  = 5,
    parameter  int TAG_BITS    = 20,
    localparam int WAY_BITS    = way_bits(N_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [TAG_BITS-1:0]   req_tag,
    input  logic [INDEX_BITS-1:0] req_index,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [WAY_BITS-1:0]   resp_way,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_ack
);

    state_e                state_q, state_d;
    logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
    logic [INDEX_BITS-1:0] req_index_q, req_index_d;
    logic                  req_write_q, req_write_d;
    logic [WAY_BITS-1:0]   victim_q, victim_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [WAY_BITS-1:0]   resp_way_q, resp_way_d;
    logic                  ack_q, ack_d;

    logic [TAG_BITS-1:0] tag_q   [NUM_SETS][N_WAYS];
    logic [TAG_BITS-1:0] tag_d   [NUM_SETS][N_WAYS];
    logic                valid_q [NUM_SETS][N_WAYS];
    logic                valid_d [NUM_SETS][N_WAYS];
    logic                dirty_q [NUM_SETS][N_WAYS];
    logic                dirty_d [NUM_SETS][N_WAYS];

    logic                hit, has_invalid;
    logic [WAY_BITS-1:0] hit_way, inv_way, miss_way, lru_victim;
    logic                lru_upd_en;
    logic [WAY_BITS-1:0] lru_upd_way;

    lru_tracker #(
        .N_WAYS     (N_WAYS),
        .NUM_SETS   (NUM_SETS),
        .INDEX_BITS (INDEX_BITS)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .upd_en    (lru_upd_en),
        .upd_index (req_index_q),
        .upd_way   (lru_upd_way),
        .vic_index (req_index_q),
        .vic_way   (lru_victim)
    );

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        inv_way     = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_index_q][w] && tag_q[req_index_q][w] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[req_index_q][w]) begin
                has_invalid = 1'b1;
                inv_way     = WAY_BITS'(w);
            end
        end
        miss_way = has_invalid ? inv_way : lru_victim;
    end

    always_comb begin
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        req_index_d = req_index_q;
        req_write_d = req_write_q;
        victim_d    = victim_q;
        resp_hit_d  = resp_hit_q;
        resp_way_d  = resp_way_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        lru_upd_en  = 1'b0;
        lru_upd_way = '0;
        // Ack is registered and only captured while waiting, so an ack that
        // coincides with the request handshake is never taken.
        ack_d       = mem_ack && (state_q == ST_WB_WAIT || state_q == ST_RF_WAIT);

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_tag_d   = req_tag;
                    req_index_d = req_index;
                    req_write_d = req_write;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    dirty_d[req_index_q][hit_way] = dirty_q[req_index_q][hit_way] | req_write_q;
                    lru_upd_en  = 1'b1;
                    lru_upd_way = hit_way;
                    resp_hit_d  = 1'b1;
                    resp_way_d  = hit_way;
                    state_d     = ST_RESPOND;
                end else begin
                    victim_d = miss_way;
                    state_d  = (valid_q[req_index_q][miss_way] && dirty_q[req_index_q][miss_way])
                               ? ST_WB_REQ : ST_RF_REQ;
                end
            end
            ST_WB_REQ:  if (mem_req_ready) state_d = ST_WB_WAIT;
            ST_WB_WAIT: if (ack_q)         state_d = ST_RF_REQ;
            ST_RF_REQ:  if (mem_req_ready) state_d = ST_RF_WAIT;
            ST_RF_WAIT: begin
                if (ack_q) begin
                    tag_d[req_index_q][victim_q]   = req_tag_q;
                    valid_d[req_index_q][victim_q] = 1'b1;
                    dirty_d[req_index_q][victim_q] = req_write_q;
                    lru_upd_en  = 1'b1;
                    lru_upd_way = victim_q;
                    resp_hit_d  = 1'b0;
                    resp_way_d  = victim_q;
                    state_d     = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_write_q <= 1'b0;
            victim_q    <= '0;
            resp_hit_q  <= 1'b0;
            resp_way_q  <= '0;
            ack_q       <= 1'b0;
            // NOTE: the tag arrays are plain flops and clear with reset, so an aborted refill leaves no stale line.
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < N_WAYS; w++) begin
                    tag_q[s][w]   <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            req_index_q <= req_index_d;
            req_write_q <= req_write_d;
            victim_q    <= victim_d;
            resp_hit_q  <= resp_hit_d;
            resp_way_q  <= resp_way_d;
            ack_q       <= ack_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESPOND);
    assign resp_hit      = resp_hit_q;
    assign resp_way      = resp_way_q;
    assign mem_req_valid = (state_q == ST_WB_REQ) || (state_q == ST_RF_REQ);
    assign mem_req_write = (state_q == ST_WB_REQ);

    always_comb begin
        mem_req_addr = '0;
        if (state_q == ST_WB_REQ) begin
            mem_req_addr = ADDR_WIDTH'(block_addr(64'(tag_q[req_index_q][victim_q]),
                                                  64'(req_index_q), INDEX_BITS, OFFSET_BITS));
        end else if (state_q == ST_RF_REQ) begin
            mem_req_addr = ADDR_WIDTH'(block_addr(64'(req_tag_q), 64'(req_index_q),
                                                  INDEX_BITS, OFFSET_BITS));
        end
    end

endmodule
